csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have ports: clk  in  1  core clock, rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: csr_wbk_v_q_i  in  1  CSR write valid from execute.
REQ-004 SHALL have ports: csr_adr_q_i  in  12  CSR write address; csr_data_q_i  in  XLEN  write data.
REQ-005 SHALL have ports: exception_q_i  in  1  trap pulse; mcause_q_i, mtval_q_i, mepc_q_i  in  XLEN  trap info.
REQ-006 SHALL have ports: core_mode_q_i  in  2  privilege at trap; mret_q_i  in  1  mret retiring; instret_i  in  1  instruction retired.
REQ-007 SHALL have ports: csr_rd_adr_i  in  12  decode read address; csr_rd_we_i  in  1  decoded instruction writes the CSR.
REQ-008 SHALL have ports: csr_rd_data_o  out  XLEN  read data; csr_rd_illegal_o  out  1  access illegal.
REQ-009 SHALL have ports: mepc_q_o, mtvec_q_o, mstatus_q_o  out  XLEN  registered CSR values.
REQ-010 SHALL use parameter XLEN, default 32, datapath width (only 32 supported).

Function
REQ-011 SHALL implement: mstatus 0x300, misa 0x301 (RO 0x40000100), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (RO 0), mhartid 0xF14 (RO 0).
REQ-012 SHALL implement mstatus bits MIE[3], MPIE[7], MPP[12:11] only; other bits read 0, writes to them ignored.
REQ-013 SHALL force mtvec[1:0] and mepc[1:0] to 0 on every write (direct mode, 4-byte aligned).
REQ-014 SHALL read combinationally: csr_rd_data_o = current register value of csr_rd_adr_i, no write bypass (decode bypasses via exe forward).
REQ-015 SHALL assert csr_rd_illegal_o when csr_rd_adr_i is unimplemented, or csr_rd_we_i=1 and csr_rd_adr_i[11:10]=2'b11; csr_rd_data_o=0 when illegal.
REQ-016 SHALL commit a write at the rising edge following csr_wbk_v_q_i=1; writes to read-only/unimplemented addresses are ignored silently.
REQ-017 SHALL on exception_q_i=1: mepc<=mepc_q_i&~3, mcause<=mcause_q_i, mtval<=mtval_q_i, MPIE<=MIE, MIE<=0, MPP<=core_mode_q_i, in one cycle.
REQ-018 SHALL on mret_q_i=1 (exception_q_i=0): MIE<=MPIE, MPIE<=1, MPP<=2'b00.
REQ-019 SHALL give priority exception_q_i > mret_q_i > csr_wbk_v_q_i for any register touched by more than one in the same cycle; non-colliding writes all commit.
REQ-020 SHALL drive mepc_q_o, mtvec_q_o, mstatus_q_o straight from flops (value visible the cycle after update).

Reset
REQ-021 SHALL on reset_n=0 immediately clear mstatus, mie, mtvec, mscratch, mepc, mcause, mtval and counters to 0, independent of clk.
REQ-022 SHALL, after reset release, apply no update before the first rising clk edge; a trap asserted in the release cycle is captured at that edge.

Configuration
REQ-023 SHALL, with macro CSR_COUNTERS_EN defined, implement 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82), plus RO shadows cycle 0xC00/0xC80 and instret 0xC02/0xC82.
REQ-024 SHALL increment mcycle every cycle and minstret when instret_i=1, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0; low-to-high carry in the same cycle.
REQ-025 SHALL, when a half is written, load the written half with write data, hold the other half, and skip that cycle's increment.
REQ-026 SHALL, without CSR_COUNTERS_EN, omit counter flops; counter addresses read 0, writes ignored, csr_rd_illegal_o=0 for reads.

Verification
REQ-027 SHALL cover: write 0x305 with 0x8000_0103 -> mtvec_q_o=0x8000_0100 next cycle; read 0x305 returns same.
REQ-028 SHALL cover: MIE=1, exception_q_i=1, mcause_q_i=2, mepc_q_i=0x104, core_mode_q_i=3 -> mepc=0x104, mcause=2, MIE=0, MPIE=1, MPP=3.
REQ-029 SHALL cover: same-cycle exception and csr write of mepc=0x200 -> mepc=exception value; then mret -> MIE=1, MPIE=1, MPP=0.
REQ-030 SHALL cover: csr_rd_adr_i=0xC00 with csr_rd_we_i=1 -> csr_rd_illegal_o=1; 0x7C0 read -> illegal=1, data 0.
REQ-031 SHALL cover (CSR_COUNTERS_EN): write mcycle=0xFFFF_FFFF, mcycleh=0 -> next cycle mcycleh=1, mcycle=0; instret_i held 5 cycles -> minstret +5.
REQ-032 SHALL cover: reset_n pulsed low mid-trap -> all registers 0 asynchronously, no capture.

Source files
------------

// File: rtl/csr_file_if.sv
// rtl/csr_file_if.sv - CSR file bus: writeback/trap inputs, decode read port, registered CSR outputs
interface csr_file_if #(
    parameter int XLEN = 32
);
    logic            csr_wbk_v_q_i;
    logic [11:0]     csr_adr_q_i;
    logic [XLEN-1:0] csr_data_q_i;
    logic            exception_q_i;
    logic [XLEN-1:0] mcause_q_i;
    logic [XLEN-1:0] mtval_q_i;
    logic [XLEN-1:0] mepc_q_i;
    logic [1:0]      core_mode_q_i;
    logic            mret_q_i;
    logic            instret_i;
    logic [11:0]     csr_rd_adr_i;
    logic            csr_rd_we_i;
    logic [XLEN-1:0] csr_rd_data_o;
    logic            csr_rd_illegal_o;
    logic [XLEN-1:0] mepc_q_o;
    logic [XLEN-1:0] mtvec_q_o;
    logic [XLEN-1:0] mstatus_q_o;

    modport master (
        output csr_wbk_v_q_i, csr_adr_q_i, csr_data_q_i,
        output exception_q_i, mcause_q_i, mtval_q_i, mepc_q_i, core_mode_q_i,
        output mret_q_i, instret_i, csr_rd_adr_i, csr_rd_we_i,
        input  csr_rd_data_o, csr_rd_illegal_o, mepc_q_o, mtvec_q_o, mstatus_q_o
    );

    modport slave (
        input  csr_wbk_v_q_i, csr_adr_q_i, csr_data_q_i,
        input  exception_q_i, mcause_q_i, mtval_q_i, mepc_q_i, core_mode_q_i,
        input  mret_q_i, instret_i, csr_rd_adr_i, csr_rd_we_i,
        output csr_rd_data_o, csr_rd_illegal_o, mepc_q_o, mtvec_q_o, mstatus_q_o
    );
endinterface

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file with trap/mret update; CSR_COUNTERS_EN adds mcycle/minstret
module csr_file #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      reset_n,
    csr_file_if.slave bus
);
    localparam logic [11:0] ADR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADR_MISA     = 12'h301;
    localparam logic [11:0] ADR_MIE      = 12'h304;
    localparam logic [11:0] ADR_MTVEC    = 12'h305;
    localparam logic [11:0] ADR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADR_MEPC     = 12'h341;
    localparam logic [11:0] ADR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADR_MTVAL    = 12'h343;
    localparam logic [11:0] ADR_MIP      = 12'h344;
    localparam logic [11:0] ADR_MHARTID  = 12'hF14;
    localparam logic [11:0] ADR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADR_MINSTRETH= 12'hB82;
    localparam logic [11:0] ADR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADR_INSTRETH = 12'hC82;

    localparam logic [XLEN-1:0] MISA_VAL   = XLEN'(32'h4000_0100);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(32'h3);

    logic            mstatus_mie_q,  mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [1:0]      mstatus_mpp_q,  mstatus_mpp_d;
    logic [XLEN-1:0] mie_q,      mie_d;
    logic [XLEN-1:0] mtvec_q,    mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;
    logic [XLEN-1:0] mtval_q,    mtval_d;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] rd_data;
    logic            rd_hit;
    logic            rd_illegal;

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[3]     = mstatus_mie_q;
        mstatus_val[7]     = mstatus_mpie_q;
        mstatus_val[12:11] = mstatus_mpp_q;
    end

    // Later assignments win: trap overrides mret, which overrides the CSR write.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mstatus_mpp_d  = mstatus_mpp_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        if (bus.csr_wbk_v_q_i) begin
            case (bus.csr_adr_q_i)
                ADR_MSTATUS: begin
                    mstatus_mie_d  = bus.csr_data_q_i[3];
                    mstatus_mpie_d = bus.csr_data_q_i[7];
                    mstatus_mpp_d  = bus.csr_data_q_i[12:11];
                end
                ADR_MIE:      mie_d      = bus.csr_data_q_i;
                ADR_MTVEC:    mtvec_d    = bus.csr_data_q_i & ALIGN_MASK;
                ADR_MSCRATCH: mscratch_d = bus.csr_data_q_i;
                ADR_MEPC:     mepc_d     = bus.csr_data_q_i & ALIGN_MASK;
                ADR_MCAUSE:   mcause_d   = bus.csr_data_q_i;
                ADR_MTVAL:    mtval_d    = bus.csr_data_q_i;
                default: ;
            endcase
        end

        if (bus.mret_q_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
            mstatus_mpp_d  = 2'b00;
        end

        if (bus.exception_q_i) begin
            mepc_d         = bus.mepc_q_i & ALIGN_MASK;
            mcause_d       = bus.mcause_q_i;
            mtval_d        = bus.mtval_q_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mstatus_mpp_d  = bus.core_mode_q_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mstatus_mpp_q  <= 2'b00;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mstatus_mpp_q  <= mstatus_mpp_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q,   mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    // A write to either half freezes the whole counter for that cycle.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, bus.instret_i};
        if (bus.csr_wbk_v_q_i) begin
            case (bus.csr_adr_q_i)
                ADR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], bus.csr_data_q_i};
                ADR_MCYCLEH:   mcycle_d   = {bus.csr_data_q_i, mcycle_q[31:0]};
                ADR_MINSTRET:  minstret_d = {minstret_q[63:32], bus.csr_data_q_i};
                ADR_MINSTRETH: minstret_d = {bus.csr_data_q_i, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`else
    logic unused_instret;
    assign unused_instret = bus.instret_i;
`endif

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b1;
        case (bus.csr_rd_adr_i)
            ADR_MSTATUS:  rd_data = mstatus_val;
            ADR_MISA:     rd_data = MISA_VAL;
            ADR_MIE:      rd_data = mie_q;
            ADR_MTVEC:    rd_data = mtvec_q;
            ADR_MSCRATCH: rd_data = mscratch_q;
            ADR_MEPC:     rd_data = mepc_q;
            ADR_MCAUSE:   rd_data = mcause_q;
            ADR_MTVAL:    rd_data = mtval_q;
            ADR_MIP:      rd_data = '0;
            ADR_MHARTID:  rd_data = '0;
`ifdef CSR_COUNTERS_EN
            ADR_MCYCLE,    ADR_CYCLE:    rd_data = mcycle_q[31:0];
            ADR_MCYCLEH,   ADR_CYCLEH:   rd_data = mcycle_q[63:32];
            ADR_MINSTRET,  ADR_INSTRET:  rd_data = minstret_q[31:0];
            ADR_MINSTRETH, ADR_INSTRETH: rd_data = minstret_q[63:32];
`else
            ADR_MCYCLE, ADR_CYCLE, ADR_MCYCLEH, ADR_CYCLEH,
            ADR_MINSTRET, ADR_INSTRET, ADR_MINSTRETH, ADR_INSTRETH: rd_data = '0;
`endif
            default:      rd_hit  = 1'b0;
        endcase
    end

    assign rd_illegal = !rd_hit || (bus.csr_rd_we_i && (bus.csr_rd_adr_i[11:10] == 2'b11));

    assign bus.csr_rd_data_o    = rd_illegal ? '0 : rd_data;
    assign bus.csr_rd_illegal_o = rd_illegal;
    assign bus.mepc_q_o         = mepc_q;
    assign bus.mtvec_q_o        = mtvec_q;
    assign bus.mstatus_q_o      = mstatus_val;
endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed table-driven bench for csr_file
module tb_csr_file;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    csr_file_if #(.XLEN(32)) bus ();

    csr_file #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        wv;
        logic [11:0] wadr;
        logic [31:0] wdata;
        logic        exc;
        logic        mret;
        logic [31:0] cause;
        logic [31:0] tval;
        logic [31:0] epc;
        logic [1:0]  mode;
        logic [11:0] radr;
        logic        rwe;
        logic [31:0] e_rd;
        logic        e_ill;
        logic [31:0] e_mepc;
        logic [31:0] e_mtvec;
        logic [31:0] e_mst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wv, logic [11:0] wadr, logic [31:0] wdata,
                                logic exc, logic mret, logic [31:0] cause, logic [31:0] tval,
                                logic [31:0] epc, logic [1:0] mode, logic [11:0] radr, logic rwe,
                                logic [31:0] e_rd, logic e_ill, logic [31:0] e_mepc,
                                logic [31:0] e_mtvec, logic [31:0] e_mst);
        vec_t v;
        v.wv = wv; v.wadr = wadr; v.wdata = wdata; v.exc = exc; v.mret = mret;
        v.cause = cause; v.tval = tval; v.epc = epc; v.mode = mode;
        v.radr = radr; v.rwe = rwe; v.e_rd = e_rd; v.e_ill = e_ill;
        v.e_mepc = e_mepc; v.e_mtvec = e_mtvec; v.e_mst = e_mst;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_pulses();
        bus.csr_wbk_v_q_i = 1'b0;
        bus.exception_q_i = 1'b0;
        bus.mret_q_i      = 1'b0;
        bus.instret_i     = 1'b0;
    endtask

    task automatic drive_write(input logic [11:0] adr, input logic [31:0] data);
        bus.csr_wbk_v_q_i = 1'b1;
        bus.csr_adr_q_i   = adr;
        bus.csr_data_q_i  = data;
        @(posedge clk);
        #1;
        bus.csr_wbk_v_q_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_check(input string name, input logic [11:0] adr, input logic [31:0] exp);
        bus.csr_rd_adr_i = adr;
        bus.csr_rd_we_i  = 1'b0;
        #1;
        check(name, bus.csr_rd_data_o, exp);
    endtask

    initial begin
        clear_pulses();
        bus.csr_adr_q_i   = '0;
        bus.csr_data_q_i  = '0;
        bus.mcause_q_i    = '0;
        bus.mtval_q_i     = '0;
        bus.mepc_q_i      = '0;
        bus.core_mode_q_i = '0;
        bus.csr_rd_adr_i  = '0;
        bus.csr_rd_we_i   = 1'b0;

        //        wv  wadr    wdata         exc mret cause tval  epc   md  radr    we  e_rd          ill e_mepc  e_mtvec       e_mst
        vecs.push_back(mk(0, 12'h000, 32'h0,        0, 0, 0, 0,      0,     0, 12'h300, 0, 32'h0,        0, 32'h0,   32'h0,        32'h0));
        vecs.push_back(mk(1, 12'h305, 32'h80000103, 0, 0, 0, 0,      0,     0, 12'h305, 0, 32'h80000100, 0, 32'h0,   32'h80000100, 32'h0));
        vecs.push_back(mk(1, 12'h300, 32'hFFFFFFFF, 0, 0, 0, 0,      0,     0, 12'h300, 0, 32'h1888,     0, 32'h0,   32'h80000100, 32'h1888));
        vecs.push_back(mk(1, 12'h300, 32'h8,        0, 0, 0, 0,      0,     0, 12'h300, 0, 32'h8,        0, 32'h0,   32'h80000100, 32'h8));
        vecs.push_back(mk(0, 12'h000, 32'h0,        1, 0, 2, 32'hDEAD, 32'h104, 3, 12'h342, 0, 32'h2,     0, 32'h104, 32'h80000100, 32'h1880));
        vecs.push_back(mk(1, 12'h300, 32'h8,        0, 0, 0, 0,      0,     0, 12'h343, 0, 32'hDEAD,     0, 32'h104, 32'h80000100, 32'h8));
        vecs.push_back(mk(1, 12'h341, 32'h200,      1, 0, 5, 0,      32'h307, 0, 12'h341, 0, 32'h304,    0, 32'h304, 32'h80000100, 32'h80));
        vecs.push_back(mk(1, 12'h300, 32'h0,        0, 1, 0, 0,      0,     0, 12'h300, 0, 32'h88,       0, 32'h304, 32'h80000100, 32'h88));
        vecs.push_back(mk(1, 12'h340, 32'h12345678, 0, 0, 0, 0,      0,     0, 12'h340, 0, 32'h12345678, 0, 32'h304, 32'h80000100, 32'h88));
        vecs.push_back(mk(1, 12'h301, 32'h0,        0, 0, 0, 0,      0,     0, 12'h301, 0, 32'h40000100, 0, 32'h304, 32'h80000100, 32'h88));
        vecs.push_back(mk(0, 12'h000, 32'h0,        0, 0, 0, 0,      0,     0, 12'hC00, 1, 32'h0,        1, 32'h304, 32'h80000100, 32'h88));
        vecs.push_back(mk(0, 12'h000, 32'h0,        0, 0, 0, 0,      0,     0, 12'h7C0, 0, 32'h0,        1, 32'h304, 32'h80000100, 32'h88));
        vecs.push_back(mk(0, 12'h000, 32'h0,        0, 0, 0, 0,      0,     0, 12'hF14, 0, 32'h0,        0, 32'h304, 32'h80000100, 32'h88));
        vecs.push_back(mk(0, 12'h000, 32'h0,        0, 0, 0, 0,      0,     0, 12'hF14, 1, 32'h0,        1, 32'h304, 32'h80000100, 32'h88));
        vecs.push_back(mk(1, 12'h304, 32'h888,      0, 0, 0, 0,      0,     0, 12'h304, 0, 32'h888,      0, 32'h304, 32'h80000100, 32'h88));
        vecs.push_back(mk(1, 12'h344, 32'hFFFFFFFF, 0, 0, 0, 0,      0,     0, 12'h344, 0, 32'h0,        0, 32'h304, 32'h80000100, 32'h88));
        vecs.push_back(mk(0, 12'h000, 32'h0,        0, 0, 0, 0,      0,     0, 12'h342, 0, 32'h5,        0, 32'h304, 32'h80000100, 32'h88));
        vecs.push_back(mk(0, 12'h000, 32'h0,        1, 1, 7, 0,      32'h400, 1, 12'h341, 0, 32'h400,    0, 32'h400, 32'h80000100, 32'h880));
        vecs.push_back(mk(1, 12'h341, 32'h12F,      0, 0, 0, 0,      0,     0, 12'h341, 0, 32'h12C,      0, 32'h12C, 32'h80000100, 32'h880));
        vecs.push_back(mk(0, 12'h000, 32'h0,        0, 0, 0, 0,      0,     0, 12'h305, 1, 32'h80000100, 0, 32'h12C, 32'h80000100, 32'h880));

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            bus.csr_wbk_v_q_i = vecs[i].wv;
            bus.csr_adr_q_i   = vecs[i].wadr;
            bus.csr_data_q_i  = vecs[i].wdata;
            bus.exception_q_i = vecs[i].exc;
            bus.mret_q_i      = vecs[i].mret;
            bus.mcause_q_i    = vecs[i].cause;
            bus.mtval_q_i     = vecs[i].tval;
            bus.mepc_q_i      = vecs[i].epc;
            bus.core_mode_q_i = vecs[i].mode;
            bus.csr_rd_adr_i  = vecs[i].radr;
            bus.csr_rd_we_i   = vecs[i].rwe;
            @(posedge clk);
            #1;
            clear_pulses();
            #1;
            check($sformatf("v%0d_rd_data", i), bus.csr_rd_data_o, vecs[i].e_rd);
            check($sformatf("v%0d_illegal", i), {31'd0, bus.csr_rd_illegal_o}, {31'd0, vecs[i].e_ill});
            check($sformatf("v%0d_mepc", i), bus.mepc_q_o, vecs[i].e_mepc);
            check($sformatf("v%0d_mtvec", i), bus.mtvec_q_o, vecs[i].e_mtvec);
            check($sformatf("v%0d_mstatus", i), bus.mstatus_q_o, vecs[i].e_mst);
            @(negedge clk);
        end
        bus.csr_rd_we_i = 1'b0;

        // Reset asserted while a trap is pending: clears immediately, nothing captured.
        bus.exception_q_i = 1'b1;
        bus.mepc_q_i      = 32'h800;
        bus.mcause_q_i    = 32'h9;
        bus.core_mode_q_i = 2'b11;
        bus.csr_rd_adr_i  = 12'h340;
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_mepc", bus.mepc_q_o, 32'h0);
        check("rst_async_mtvec", bus.mtvec_q_o, 32'h0);
        check("rst_async_mstatus", bus.mstatus_q_o, 32'h0);
        check("rst_async_mscratch", bus.csr_rd_data_o, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_mepc", bus.mepc_q_o, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_release_no_update", bus.mepc_q_o, 32'h0);
        @(posedge clk);
        #1;
        bus.exception_q_i = 1'b0;
        check("rst_release_trap_mepc", bus.mepc_q_o, 32'h800);
        check("rst_release_trap_mstatus", bus.mstatus_q_o, 32'h1800);
        read_check("rst_release_trap_mcause", 12'h342, 32'h9);
        @(negedge clk);

`ifdef CSR_COUNTERS_EN
        drive_write(12'hB00, 32'hFFFF_FFFF);
        drive_write(12'hB80, 32'h0);
        @(posedge clk);
        #1;
        read_check("cnt_mcycleh_carry", 12'hB80, 32'h1);
        read_check("cnt_mcycle_wrap_lo", 12'hB00, 32'h0);
        read_check("cnt_cycleh_shadow", 12'hC80, 32'h1);
        @(negedge clk);
        drive_write(12'hB02, 32'h0);
        drive_write(12'hB82, 32'h0);
        bus.instret_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.instret_i = 1'b0;
        read_check("cnt_minstret_plus5", 12'hB02, 32'h5);
        read_check("cnt_instret_shadow", 12'hC02, 32'h5);
        read_check("cnt_minstreth", 12'hB82, 32'h0);
        @(negedge clk);
        drive_write(12'hB80, 32'hFFFF_FFFF);
        drive_write(12'hB00, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        read_check("cnt_wrap64_lo", 12'hB00, 32'h0);
        read_check("cnt_wrap64_hi", 12'hB80, 32'h0);
        @(negedge clk);
`else
        drive_write(12'hB00, 32'h5);
        read_check("nocnt_mcycle_zero", 12'hB00, 32'h0);
        check("nocnt_mcycle_legal", {31'd0, bus.csr_rd_illegal_o}, 32'h0);
        read_check("nocnt_cycle_zero", 12'hC00, 32'h0);
        check("nocnt_cycle_legal", {31'd0, bus.csr_rd_illegal_o}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
